// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if
// Control, edge-pulse and serial-data bundle for the SPI shift engine.
// The "master" side starts transfers and supplies edges and sdi; the
// "slave" side is the shift engine itself.
interface spi_shift_engine_if #(
  parameter int MAX_LEN = 32
);
  logic                       go;
  logic [$clog2(MAX_LEN)-1:0] len;
  logic                       lsb;
  logic                       tx_negedge;
  logic                       rx_negedge;
  logic                       pos_edge;
  logic                       neg_edge;
  logic [MAX_LEN-1:0]         tx_data;
  logic                       sdi;
  logic                       sdo;
  logic                       busy;
  logic                       last_clk;
  logic                       done;
  logic [MAX_LEN-1:0]         rx_data;

  modport master (
    output go, len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, tx_data, sdi,
    input  sdo, busy, last_clk, done, rx_data
  );

  modport slave (
    input  go, len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, tx_data, sdi,
    output sdo, busy, last_clk, done, rx_data
  );
endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine
// Serialises one character of 1..MAX_LEN bits onto sdo and collects the
// same number of bits from sdi, clocked by edge pulses from an external
// SPI clock generator. All transfer settings are latched on go.
// Optional macro SPI_SHIFT_RX_HOLD_EN: when defined, rx_data comes from a
// holding register loaded on the done cycle, so it stays stable during the
// following transfer; otherwise rx_data is the live receive register.
module spi_shift_engine #(
  parameter int MAX_LEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_shift_engine_if.slave   bus
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] txShift_q, txShift_d;
  logic [MAX_LEN-1:0] rxShift_q, rxShift_d;
  logic [CW-1:0]      txCnt_q, txCnt_d;
  logic [CW-1:0]      rxCnt_q, rxCnt_d;
  logic [CW-1:0]      lenEff_q, lenEff_d;
  logic               lsb_q, lsb_d;
  logic               txNeg_q, txNeg_d;
  logic               rxNeg_q, rxNeg_d;
  logic               sdo_q, sdo_d;

  logic [CW-1:0]      lenReq;
  logic [IW-1:0]      txIdx, rxIdx;
  logic               txEdge, rxEdge;
  logic               inShift, xferDone;

  // Requested length mapped to a bit count: 0 and out-of-range values mean a full word
  always_comb begin
    lenReq = CW'(bus.len);
    if (bus.len == '0 || lenReq > CW'(MAX_LEN)) begin
      lenReq = CW'(MAX_LEN);
    end
  end

  assign inShift  = (state_q == SHIFT);
  assign txEdge   = txNeg_q ? bus.neg_edge : bus.pos_edge;
  assign rxEdge   = rxNeg_q ? bus.neg_edge : bus.pos_edge;
  assign txIdx    = IW'(lsb_q ? (lenEff_q - txCnt_q) : (txCnt_q - CW'(1)));
  assign rxIdx    = IW'(lsb_q ? (lenEff_q - rxCnt_q) : (rxCnt_q - CW'(1)));
  assign xferDone = inShift && (rxCnt_q == '0);

  // Next-state logic: load on go in IDLE, then consume tx and rx edges independently
  always_comb begin
    state_d   = state_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    txCnt_d   = txCnt_q;
    rxCnt_d   = rxCnt_q;
    lenEff_d  = lenEff_q;
    lsb_d     = lsb_q;
    txNeg_d   = txNeg_q;
    rxNeg_d   = rxNeg_q;
    sdo_d     = sdo_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          txShift_d = bus.tx_data;
          rxShift_d = '0;
          txCnt_d   = lenReq;
          rxCnt_d   = lenReq;
          lenEff_d  = lenReq;
          lsb_d     = bus.lsb;
          txNeg_d   = bus.tx_negedge;
          rxNeg_d   = bus.rx_negedge;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (txEdge && (txCnt_q != '0)) begin
          sdo_d   = txShift_q[txIdx];
          txCnt_d = txCnt_q - CW'(1);
        end
        if (rxEdge && (rxCnt_q != '0)) begin
          rxShift_d[rxIdx] = bus.sdi;
          rxCnt_d          = rxCnt_q - CW'(1);
        end
        if (rxCnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      txShift_q <= '0;
      rxShift_q <= '0;
      txCnt_q   <= '0;
      rxCnt_q   <= '0;
      lenEff_q  <= '0;
      lsb_q     <= 1'b0;
      txNeg_q   <= 1'b0;
      rxNeg_q   <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      txCnt_q   <= txCnt_d;
      rxCnt_q   <= rxCnt_d;
      lenEff_q  <= lenEff_d;
      lsb_q     <= lsb_d;
      txNeg_q   <= txNeg_d;
      rxNeg_q   <= rxNeg_d;
      sdo_q     <= sdo_d;
    end
  end

  assign bus.sdo      = sdo_q;
  assign bus.busy     = inShift;
  assign bus.last_clk = inShift && (rxCnt_q == CW'(1));
  assign bus.done     = xferDone;

`ifdef SPI_SHIFT_RX_HOLD_EN
  logic [MAX_LEN-1:0] rxHold_q;

  // Holding copy of the received word, refreshed only when a transfer completes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxHold_q <= '0;
    end else if (xferDone) begin
      rxHold_q <= rxShift_q;
    end
  end

  assign bus.rx_data = rxHold_q;
`else
  assign bus.rx_data = rxShift_q;
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine
// Directed bench for spi_shift_engine (MAX_LEN = 32). The SPI clock
// generator is modelled by driving pos_edge/neg_edge pulses by hand; sdi is
// either looped back from sdo or driven from a pattern.
// Define SPI_SHIFT_RX_HOLD_EN to also exercise the rx holding register.
module tb_spi_shift_engine;

  logic clk_i;
  logic rst_i;
  logic loopback;
  logic sdiDrv;
  int   testsRun;
  int   testsFailed;
  int   doneCount;
  int   doneMark;

  logic seqA5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic pat6  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  spi_shift_engine_if #(.MAX_LEN(32)) bus ();

  spi_shift_engine #(.MAX_LEN(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  assign bus.sdi = loopback ? bus.sdo : sdiDrv;

  // Free-running system clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count clock edges at which done is seen high
  always @(posedge clk_i) begin
    if (bus.done) doneCount++;
  end

  // Drive one cycle of edge pulses, then sample just after the clock edge
  task automatic applyStimulus(input logic p, input logic n);
    bus.pos_edge = p;
    bus.neg_edge = n;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
  endtask

  // Latch settings with a single go cycle (drive on neg_edge, sample on pos_edge)
  task automatic startXfer(input logic [31:0] data, input logic [4:0] len, input logic lsbFirst);
    bus.tx_data    = data;
    bus.len        = len;
    bus.lsb        = lsbFirst;
    bus.tx_negedge = 1'b1;
    bus.rx_negedge = 1'b0;
    bus.go         = 1'b1;
    applyStimulus(1'b0, 1'b0);
    bus.go         = 1'b0;
  endtask

  task automatic runBits(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    doneCount   = 0;
    loopback    = 1'b1;
    sdiDrv      = 1'b0;
    rst_i       = 1'b1;
    bus.go         = 1'b0;
    bus.len        = '0;
    bus.lsb        = 1'b0;
    bus.tx_negedge = 1'b0;
    bus.rx_negedge = 1'b0;
    bus.pos_edge   = 1'b0;
    bus.neg_edge   = 1'b0;
    bus.tx_data    = '0;

    // Reset state
    #3;
    checkOutput("rst busy", bus.busy, 0);
    checkOutput("rst done", bus.done, 0);
    checkOutput("rst sdo", bus.sdo, 0);
    checkOutput("rst last_clk", bus.last_clk, 0);
    checkOutput("rst rx_data", bus.rx_data, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("post-rst no start", bus.busy, 0);

    // MSB first, 8 bits of 0xA5 looped back
    doneMark = doneCount;
    startXfer(32'hA5, 5'd8, 1'b0);
    checkOutput("a5 busy after go", bus.busy, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput($sformatf("a5 sdo bit%0d", i), bus.sdo, 32'(seqA5[i]));
      checkOutput($sformatf("a5 last_clk bit%0d", i), bus.last_clk, (i == 7) ? 1 : 0);
      if (i == 7) begin
        applyStimulus(1'b0, 1'b1);
        checkOutput("a5 extra tx edge at count 0", bus.sdo, 1);
      end
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("a5 done bit%0d", i), bus.done, (i == 7) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("a5 busy end", bus.busy, 0);
    checkOutput("a5 done end", bus.done, 0);
    checkOutput("a5 rx_data", bus.rx_data, 32'h0000_00A5);
    checkOutput("a5 done pulses", doneCount - doneMark, 1);

    // LSB first, full 32-bit word 0x80000001
    doneMark = doneCount;
    startXfer(32'h8000_0001, 5'd0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (i == 0)  checkOutput("w32 first sdo", bus.sdo, 1);
      if (i == 15) checkOutput("w32 mid sdo", bus.sdo, 0);
      if (i == 31) checkOutput("w32 last sdo", bus.sdo, 1);
      checkOutput($sformatf("w32 last_clk bit%0d", i), bus.last_clk, (i == 31) ? 1 : 0);
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("w32 done bit%0d", i), bus.done, (i == 31) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("w32 rx_data", bus.rx_data, 32'h8000_0001);
    checkOutput("w32 done pulses", doneCount - doneMark, 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("idle edges ignored busy", bus.busy, 0);
    checkOutput("idle sdo holds", bus.sdo, 1);

    // Divider 0: both edges every cycle, len 4, 0x6, sdi driven from a pattern
    loopback = 1'b0;
    startXfer(32'h6, 5'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      sdiDrv = pat6[k];
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("div0 sdo cyc%0d", k), bus.sdo, 32'(pat6[k]));
      checkOutput($sformatf("div0 done cyc%0d", k), bus.done, (k == 3) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("div0 busy end", bus.busy, 0);
    checkOutput("div0 rx_data", bus.rx_data, 32'h6);
    loopback = 1'b1;

    // go re-pulsed mid-transfer and in the done cycle
    doneMark = doneCount;
    startXfer(32'h5A, 5'd8, 1'b0);
`ifdef SPI_SHIFT_RX_HOLD_EN
    checkOutput("hold rx_data kept at start", bus.rx_data, 32'h6);
`else
    checkOutput("live rx_data cleared at start", bus.rx_data, 0);
`endif
    runBits(3);
    bus.go = 1'b1;
    applyStimulus(1'b0, 1'b1);
    bus.go = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("5a busy mid go", bus.busy, 1);
    runBits(4);
    checkOutput("5a done", bus.done, 1);
    bus.go = 1'b1;
    applyStimulus(1'b0, 1'b0);
    bus.go = 1'b0;
    checkOutput("5a go in done cycle ignored", bus.busy, 0);
    checkOutput("5a rx_data", bus.rx_data, 32'h5A);
    applyStimulus(1'b0, 1'b0);
    checkOutput("5a still idle", bus.busy, 0);
    checkOutput("5a done pulses", doneCount - doneMark, 1);

    // Reset after 3 bits of an 8-bit transfer, then a clean 0x3C transfer
    startXfer(32'hFF, 5'd8, 1'b0);
    runBits(3);
    rst_i = 1'b1;
    #1;
    checkOutput("midrst busy", bus.busy, 0);
    checkOutput("midrst sdo", bus.sdo, 0);
    checkOutput("midrst rx_data", bus.rx_data, 0);
    checkOutput("midrst last_clk", bus.last_clk, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("postrst idle", bus.busy, 0);
    doneMark = doneCount;
    startXfer(32'h3C, 5'd8, 1'b0);
    runBits(8);
    checkOutput("3c done", bus.done, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("3c rx_data", bus.rx_data, 32'h3C);
    checkOutput("3c done pulses", doneCount - doneMark, 1);

`ifdef SPI_SHIFT_RX_HOLD_EN
    // Back-to-back 0x11 then 0x22 with the holding register
    startXfer(32'h11, 5'd8, 1'b0);
    runBits(8);
    checkOutput("hold 11 done", bus.done, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold after 11", bus.rx_data, 32'h11);
    startXfer(32'h22, 5'd8, 1'b0);
    runBits(4);
    checkOutput("hold during 22", bus.rx_data, 32'h11);
    runBits(4);
    checkOutput("hold at 22 done", bus.rx_data, 32'h11);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold after 22", bus.rx_data, 32'h22);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter: MAX_LEN, default 32, maximum character length in bits (legal range 8..32).
REQ-002 SHALL have port: clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: go  input  1  start request, sampled only when idle.
REQ-005 SHALL have port: len  input  $clog2(MAX_LEN)  character length; 0 means MAX_LEN bits.
REQ-006 SHALL have port: lsb  input  1  1 = LSB first, 0 = MSB first.
REQ-007 SHALL have port: tx_negedge / rx_negedge  input  1 each  drive/sample on neg_edge when 1, on pos_edge when 0.
REQ-008 SHALL have port: pos_edge / neg_edge  input  1 each  single-cycle edge pulses from the SPI clock generator.
REQ-009 SHALL have port: tx_data  input  MAX_LEN  word to transmit, right-aligned.
REQ-010 SHALL have port: sdi  input  1  serial data from the slave.
REQ-011 SHALL have port: sdo  output  1  serial data to the slave.
REQ-012 SHALL have port: busy  output  1  transfer in progress; drives the clock generator enable.
REQ-013 SHALL have port: last_clk  output  1  final bit in flight; drives the clock generator last-clock input.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at transfer completion.
REQ-015 SHALL have port: rx_data  output  MAX_LEN  received word, right-aligned; upper bits zero.

Function
REQ-016 SHALL implement two states, IDLE and SHIFT; reset enters IDLE.
REQ-017 SHALL, in IDLE with go=1: load tx shift register from tx_data, tx_cnt = rx_cnt = effective length, clear rx shift register, enter SHIFT, assert busy the next cycle.
REQ-018 SHALL ignore go while in SHIFT; tx_data, len, lsb, tx_negedge and rx_negedge are captured at start and held for the whole transfer.
REQ-019 SHALL, on each selected tx edge in SHIFT with tx_cnt>0: set sdo to bit [tx_cnt-1] (MSB first) or bit [len_eff-tx_cnt] (LSB first), then decrement tx_cnt.
REQ-020 SHALL, on each selected rx edge in SHIFT with rx_cnt>0: place sdi at bit [rx_cnt-1] (MSB first) or bit [len_eff-rx_cnt] (LSB first), then decrement rx_cnt.
REQ-021 SHALL assert last_clk combinationally when in SHIFT and rx_cnt==1.
REQ-022 SHALL, on the first cycle rx_cnt==0 in SHIFT, return to IDLE, deassert busy and pulse done for exactly one cycle.
REQ-023 SHALL process a tx edge and an rx edge asserted in the same cycle independently and in that same cycle.
REQ-024 SHALL ignore pos_edge/neg_edge in IDLE; sdo holds its last driven value in IDLE.
REQ-025 SHALL ensure a go in the same cycle as done is ignored; a new transfer starts at the earliest on the cycle after done.
REQ-026 SHALL not underflow tx_cnt/rx_cnt; extra edges at count 0 are ignored.

Reset
REQ-027 SHALL, on rst_i asserted (including mid-transfer), immediately force IDLE, sdo=0, busy=0, last_clk=0, done=0, counters=0, shift registers and rx_data=0.
REQ-028 SHALL, after rst_i deasserts, need a fresh go before any transfer starts.

Configuration
REQ-029 SHALL honour macro SPI_SHIFT_RX_HOLD_EN: when defined, rx_data is a separate holding register updated only on the done cycle and stable during the next transfer; when undefined, rx_data is the live rx shift register, valid only while busy=0.

Verification
REQ-030 SHALL cover: MSB first, len=8, tx_data=0xA5, sdi looped to sdo, tx_negedge=1, rx_negedge=0 -> sdo sequence 1,0,1,0,0,1,0,1; rx_data=0x000000A5; one done pulse.
REQ-031 SHALL cover: LSB first, len=0 (32 bits), tx_data=0x80000001 -> first sdo bit 1, last sdo bit 1; exactly 32 tx edges consumed; last_clk high only during the 32nd bit.
REQ-032 SHALL cover: pos_edge and neg_edge both pulsed every cycle (divider 0), len=4, tx_data=0x6 -> done 4 cycles after the first edge; rx_data=0x6.
REQ-033 SHALL cover: go re-pulsed mid-transfer and in the done cycle -> no restart, no extra done; the next go starts normally.
REQ-034 SHALL cover: rst_i asserted after 3 bits of an 8-bit transfer -> busy, sdo and rx_data are 0 in the same cycle; the next go transfers 0x3C correctly.
REQ-035 SHALL cover: with SPI_SHIFT_RX_HOLD_EN defined, back-to-back transfers 0x11 then 0x22 -> rx_data stays 0x11 until the second done, then becomes 0x22.
